// File: rtl/rose_followup_checker.sv
// rtl/rose_followup_checker.sv - monitor for "rise of a, then rise of b within [MIN_DLY, MAX_DLY] samples"
// One attempt at a time; registered pass/fail pulses plus saturating event counters.
module rose_followup_checker #(
  parameter int MIN_DLY = 1,
  parameter int MAX_DLY = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             clr,
  output logic             busy,
  output logic             pass_pulse,
  output logic             fail_pulse,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] ovr_cnt
);

  localparam int DW = (MAX_DLY < 2) ? 1 : $clog2(MAX_DLY + 1);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t        state, state_n;
  logic [DW-1:0] dly, dly_n;
  logic          a_q, b_q;
  logic          rose_a, rose_b, in_win;
  logic          pass_ev, fail_ev, ovr_ev;

  assign rose_a = a & ~a_q;
  assign rose_b = b & ~b_q;
  assign in_win = (dly >= DW'(MIN_DLY)) && (dly <= DW'(MAX_DLY));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      dly        <= '0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      pass_pulse <= 1'b0;
      fail_pulse <= 1'b0;
      pass_cnt   <= '0;
      fail_cnt   <= '0;
      ovr_cnt    <= '0;
    end else begin
      a_q <= a;
      b_q <= b;
      if (clr) begin
        state      <= IDLE;
        dly        <= '0;
        pass_pulse <= 1'b0;
        fail_pulse <= 1'b0;
        pass_cnt   <= '0;
        fail_cnt   <= '0;
        ovr_cnt    <= '0;
      end else begin
        state      <= state_n;
        dly        <= dly_n;
        pass_pulse <= pass_ev;
        fail_pulse <= fail_ev;
        // Counters stick at all-ones rather than wrapping.
        if (pass_ev && (pass_cnt != '1)) pass_cnt <= pass_cnt + CNT_W'(1);
        if (fail_ev && (fail_cnt != '1)) fail_cnt <= fail_cnt + CNT_W'(1);
        if (ovr_ev  && (ovr_cnt  != '1)) ovr_cnt  <= ovr_cnt  + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_n = state;
    dly_n   = dly;
    pass_ev = 1'b0;
    fail_ev = 1'b0;
    ovr_ev  = 1'b0;
    case (state)
      IDLE: begin
        if (rose_a) begin
          state_n = WAIT;
          dly_n   = DW'(1);
        end
      end
      WAIT: begin
        pass_ev = rose_b && in_win;
        fail_ev = !pass_ev && (dly == DW'(MAX_DLY));
        if (pass_ev || fail_ev) begin
          // A rise of a on the decision edge immediately opens the next attempt.
          state_n = rose_a ? WAIT : IDLE;
          dly_n   = rose_a ? DW'(1) : '0;
        end else begin
          ovr_ev  = rose_a;
          dly_n   = dly + DW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        dly_n   = '0;
      end
    endcase
  end

  always_comb begin
    busy = (state == WAIT);
  end

endmodule

// File: tb/tb_rose_followup_checker.sv
// tb/tb_rose_followup_checker.sv - directed self-checking bench for rose_followup_checker
// Three instances: 1/1 window, 2..4 window, and 1/1 with 2-bit counters.
module tb_rose_followup_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic a1 = 0, b1 = 0, c1 = 0;
  logic a2 = 0, b2 = 0, c2 = 0;
  logic a3 = 0, b3 = 0, c3 = 0;

  logic        busy1, pp1, fp1;
  logic [15:0] pc1, fc1, oc1;
  logic        busy2, pp2, fp2;
  logic [15:0] pc2, fc2, oc2;
  logic        busy3, pp3, fp3;
  logic [1:0]  pc3, fc3, oc3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rose_followup_checker #(.MIN_DLY(1), .MAX_DLY(1), .CNT_W(16)) u_dut11 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .clr(c1), .busy(busy1),
    .pass_pulse(pp1), .fail_pulse(fp1), .pass_cnt(pc1), .fail_cnt(fc1), .ovr_cnt(oc1));

  rose_followup_checker #(.MIN_DLY(2), .MAX_DLY(4), .CNT_W(16)) u_dut24 (
    .clk(clk), .rst(rst), .a(a2), .b(b2), .clr(c2), .busy(busy2),
    .pass_pulse(pp2), .fail_pulse(fp2), .pass_cnt(pc2), .fail_cnt(fc2), .ovr_cnt(oc2));

  rose_followup_checker #(.MIN_DLY(1), .MAX_DLY(1), .CNT_W(2)) u_dut_sat (
    .clk(clk), .rst(rst), .a(a3), .b(b3), .clr(c3), .busy(busy3),
    .pass_pulse(pp3), .fail_pulse(fp3), .pass_cnt(pc3), .fail_cnt(fc3), .ovr_cnt(oc3));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one posedge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check("rst_busy", busy1, 0);
    check("rst_pass_pulse", pp1, 0);
    check("rst_fail_pulse", fp1, 0);
    check("rst_pass_cnt", pc1, 0);
    check("rst_ovr_cnt", oc2, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick();

    // 1: next-cycle pass
    a1 = 1; tick();
    check("t1_busy_wait", busy1, 1);
    check("t1_no_early_pass", pp1, 0);
    b1 = 1; tick();
    check("t1_pass_pulse", pp1, 1);
    check("t1_pass_cnt", pc1, 1);
    check("t1_fail_cnt", fc1, 0);
    check("t1_busy_done", busy1, 0);
    tick();
    check("t1_pulse_one_cycle", pp1, 0);
    a1 = 0; b1 = 0; tick();

    // 2: a and b rise together, b stays high -> fail
    a1 = 1; b1 = 1; tick();
    check("t2_busy", busy1, 1);
    check("t2_no_pass_d0", pp1, 0);
    tick();
    check("t2_fail_pulse", fp1, 1);
    check("t2_fail_cnt", fc1, 1);
    check("t2_pass_cnt", pc1, 1);
    tick();
    check("t2_fail_one_cycle", fp1, 0);
    check("t2_idle", busy1, 0);
    a1 = 0; b1 = 0; tick();

    // 3: window 2..4, early b ignored, pass at d=3
    a2 = 1; tick();
    b2 = 1; tick();
    check("t3_early_b_no_pass", pp2, 0);
    check("t3_early_b_no_fail", fp2, 0);
    check("t3_busy", busy2, 1);
    b2 = 0; tick();
    b2 = 1; tick();
    check("t3_pass_d3", pp2, 1);
    check("t3_pass_cnt", pc2, 1);
    check("t3_idle", busy2, 0);
    a2 = 0; b2 = 0; tick();

    // 3b: no b -> fail after edge k+4
    a2 = 1; tick();
    a2 = 0; tick(); tick(); tick();
    check("t3b_no_fail_yet", fp2, 0);
    check("t3b_busy_d4", busy2, 1);
    tick();
    check("t3b_fail_pulse", fp2, 1);
    check("t3b_fail_cnt", fc2, 1);
    tick();
    check("t3b_fail_one_cycle", fp2, 0);
    check("t3b_idle", busy2, 0);

    // 4: overlapping rose(a) is counted, not restarted
    a2 = 1; tick();
    a2 = 0; tick();
    a2 = 1; tick();
    check("t4_ovr_cnt", oc2, 1);
    check("t4_busy", busy2, 1);
    b2 = 1; tick();
    check("t4_pass_pulse", pp2, 1);
    check("t4_pass_cnt", pc2, 2);
    a2 = 0; b2 = 0; tick();

    // 4b: rose(a) on the fail edge starts a new attempt
    a2 = 1; tick();
    a2 = 0; tick(); tick(); tick();
    a2 = 1; tick();
    check("t4b_fail_pulse", fp2, 1);
    check("t4b_fail_cnt", fc2, 2);
    check("t4b_busy_stays", busy2, 1);
    check("t4b_ovr_unchanged", oc2, 1);
    tick();
    check("t4b_busy_next", busy2, 1);
    check("t4b_fail_one_cycle", fp2, 0);

    // 5b: clr mid-WAIT
    c2 = 1; tick();
    c2 = 0; a2 = 0;
    check("t5_clr_busy", busy2, 0);
    check("t5_clr_pass_cnt", pc2, 0);
    check("t5_clr_fail_cnt", fc2, 0);
    check("t5_clr_ovr_cnt", oc2, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t5_clr_no_fail", fp2, 0);
    end

    // 6: 2-bit pass counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      a3 = 1; tick();
      b3 = 1; tick();
      check("t6_pass_pulse", pp3, 1);
      a3 = 0; b3 = 0; tick();
    end
    check("t6_pass_cnt_sat", pc3, 3);
    check("t6_fail_cnt", fc3, 0);

    // 5: async reset between edges mid-WAIT
    a1 = 1; tick();
    check("t5_pre_rst_busy", busy1, 1);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_busy", busy1, 0);
    check("t5_rst_pass_cnt", pc1, 0);
    check("t5_rst_fail_cnt", fc1, 0);
    check("t5_rst_sat_cnt", pc3, 0);
    a1 = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_post_rst_no_pass", pp1, 0);
      check("t5_post_rst_no_fail", fp1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
